// File: rtl/gate_tt_checker.sv
// Truth-table driver/checker for a 2-input AND/OR/NOT gate block.
// Steps {in1,in2} through 00,01,10,11. Each vector is held for SETTLE_CYC
// cycles, then the gate outputs are sampled and scored. The run ends with a
// one-cycle done pulse that carries an error mask, a mismatch count and pass.
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       in1,
  output logic       in2,
  input  logic       out_and,
  input  logic       out_or,
  input  logic       out_not_in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_mask,
  output logic [3:0] err_cnt
);

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned VEC_W = 2;

  // A zero settle time would skip the drive phase entirely
  if (SETTLE_CYC == 0) begin : g_bad_settle
    $error("gate_tt_checker: SETTLE_CYC must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state;
  logic [VEC_W-1:0]   vec;
  logic [CNT_W-1:0]   cnt;

  logic [2:0]         mism_c;
  logic [3:0]         mism_cnt_c;
  logic [3:0]         mask_next_c;

  // Score the currently driven vector: {and, or, not} actual XOR expected
  always_comb begin
    mism_c      = 3'b000;
    mism_cnt_c  = 4'd0;
    mask_next_c = err_mask;
    mism_c[2]   = out_and     ^ (in1 & in2);
    mism_c[1]   = out_or      ^ (in1 | in2);
    mism_c[0]   = out_not_in1 ^ ~in1;
    mism_cnt_c  = 4'(mism_c[0]) + 4'(mism_c[1]) + 4'(mism_c[2]);
    mask_next_c[vec] = |mism_c;
  end

  // Run sequencer: accept, drive/settle, sample, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      vec      <= '0;
      cnt      <= '0;
      in1      <= 1'b0;
      in2      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_mask <= 4'd0;
      err_cnt  <= 4'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_DRIVE;
            vec      <= '0;
            cnt      <= '0;
            in1      <= 1'b0;
            in2      <= 1'b0;
            busy     <= 1'b1;
            pass     <= 1'b0;
            err_mask <= 4'd0;
            err_cnt  <= 4'd0;
          end
        end
        S_DRIVE: begin
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            state <= S_SAMPLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SAMPLE: begin
          err_mask <= mask_next_c;
          err_cnt  <= err_cnt + mism_cnt_c;
          if (vec == VEC_W'(3)) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= (mask_next_c == 4'd0);
            in1   <= 1'b0;
            in2   <= 1'b0;
          end else begin
            state      <= S_DRIVE;
            vec        <= vec + VEC_W'(1);
            cnt        <= '0;
            {in1, in2} <= vec + VEC_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: a gate model with selectable faults closes the loop.
// A timeline model predicts every output on every cycle; literal checks pin it.
module tb_gate_tt_checker;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned PER    = SETTLE + 1;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in1, in2;
  logic       out_and, out_or, out_not_in1;
  logic       busy, done, pass;
  logic [3:0] err_mask, err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mode   = 0;   // 0 good, 1 OR stuck 0, 2 NOT tied to IN1, 3 AND stuck 1

  gate_tt_checker #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in1(in1), .in2(in2),
    .out_and(out_and), .out_or(out_or), .out_not_in1(out_not_in1),
    .busy(busy), .done(done), .pass(pass),
    .err_mask(err_mask), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test, returns {and, or, not}
  function automatic logic [2:0] gate(input logic a, input logic b, input int m);
    logic [2:0] r;
    r = {a & b, a | b, ~a};
    if (m == 1) r[1] = 1'b0;
    if (m == 2) r[0] = a;
    if (m == 3) r[2] = 1'b1;
    return r;
  endfunction

  always_comb {out_and, out_or, out_not_in1} = gate(in1, in2, mode);

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: k counts edges since accept; vector v occupies k in [v*PER, (v+1)*PER)
  bit       m_run  = 0;
  bit       m_done = 0;
  bit       m_busy = 0;
  bit       m_pass = 0;
  int       m_k    = 0;
  int       m_cnt  = 0;
  bit [3:0] m_mask = 0;
  bit [1:0] m_in   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_busy = 0; m_pass = 0;
      m_k = 0; m_cnt = 0; m_mask = 0; m_in = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_run) begin
      m_k++;
      if (m_k % PER == 0) begin
        int v;
        int nm;
        logic [2:0] want, got;
        v    = m_k / PER - 1;
        want = {v[1] & v[0], v[1] | v[0], ~v[1]};
        got  = gate(v[1], v[0], mode);
        nm   = 0;
        for (int i = 0; i < 3; i++) if (want[i] != got[i]) nm++;
        m_mask[v] = (nm != 0);
        m_cnt += nm;
        if (v == 3) begin
          m_run = 0; m_done = 1; m_pass = (m_mask == 0); m_in = 0;
        end
      end
      if (m_run) m_in = 2'(m_k / PER);
    end else if (start) begin
      m_run = 1; m_k = 0; m_busy = 1; m_pass = 0;
      m_mask = 0; m_cnt = 0; m_in = 0;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("in_vec",   {6'd0, in1, in2}, {6'd0, m_in});
    chk("busy",     {7'd0, busy},     {7'd0, m_busy});
    chk("done",     {7'd0, done},     {7'd0, m_done});
    chk("pass",     {7'd0, pass},     {7'd0, m_pass});
    chk("err_mask", {4'd0, err_mask}, {4'd0, m_mask});
    chk("err_cnt",  {4'd0, err_cnt},  8'(m_cnt));
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in"},   {6'd0, in1, in2}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy},     8'd0);
    chk({tag, "_done"}, {7'd0, done},     8'd0);
    chk({tag, "_pass"}, {7'd0, pass},     8'd0);
    chk({tag, "_mask"}, {4'd0, err_mask}, 8'd0);
    chk({tag, "_cnt"},  {4'd0, err_cnt},  8'd0);
  endtask

  // Wait (bounded) for done, sampling on negedges
  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL wait_done: timeout, done never rose");
    end
  endtask

  task automatic run(input int m, input logic [3:0] e_mask, input int e_cnt, input bit e_pass,
                     input string tag);
    int t0;
    bit ok;
    mode = m;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 t0 = cyc; start = 1'b0;
    wait_done(ok);
    if (ok) begin
      chk({tag, "_latency"}, 8'(cyc - t0), 8'd12);
      chk({tag, "_busy"},    {7'd0, busy},     8'd1);
      chk({tag, "_mask"},    {4'd0, err_mask}, {4'd0, e_mask});
      chk({tag, "_cnt"},     {4'd0, err_cnt},  8'(e_cnt));
      chk({tag, "_pass"},    {7'd0, pass},     {7'd0, e_pass});
    end
    @(negedge clk);
    chk({tag, "_done_1cyc"}, {7'd0, done}, 8'd0);
    chk({tag, "_held_mask"}, {4'd0, err_mask}, {4'd0, e_mask});
  endtask

  initial begin
    bit ok;
    int dones;
    start = 1'b0;
    rst_n = 1'b0;
    #1 chk_reset_vals("rst0");
    #12 rst_n = 1'b1;

    run(0, 4'b0000, 0, 1'b1, "good");
    run(1, 4'b1110, 3, 1'b0, "or_sa0");
    run(2, 4'b1111, 4, 1'b0, "not_eq_in1");
    run(3, 4'b0111, 3, 1'b0, "and_sa1");

    // Start held high: one IDLE cycle, then a fresh accept clears the results
    mode = 1;
    @(posedge clk); #1 start = 1'b1;
    wait_done(ok);
    if (ok) begin
      chk("b2b_first_mask", {4'd0, err_mask}, 8'h0e);
      @(negedge clk);
      chk("b2b_idle_busy", {7'd0, busy}, 8'd0);
      chk("b2b_idle_mask", {4'd0, err_mask}, 8'h0e);
      @(negedge clk);
      chk("b2b_accept_busy", {7'd0, busy},     8'd1);
      chk("b2b_accept_mask", {4'd0, err_mask}, 8'd0);
      chk("b2b_accept_cnt",  {4'd0, err_cnt},  8'd0);
      chk("b2b_accept_pass", {7'd0, pass},     8'd0);
    end
    #1 start = 1'b0;
    wait_done(ok);
    @(negedge clk);

    // Reset while vector 2 is driven
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy === 1'b1 && in1 === 1'b1 && in2 === 1'b0) begin
        ok = 1;
        break;
      end
    end
    chk("reach_vec2", {7'd0, ok}, 8'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    chk("midrst_no_done", 8'(dones), 8'd0);
    chk("midrst_idle_busy", {7'd0, busy}, 8'd0);

    run(0, 4'b0000, 0, 1'b1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
